// File: rtl/sd_wb_byte_bridge.sv
// Wishbone classic 32-bit slave to SD controller byte-wide register-file bridge.
// Each word access is split into byte accesses, highest lane first, so byte-0 triggers fire last.
module sd_wb_byte_bridge #(
    parameter int ADDR_W          = 7,
    parameter int SKIP_UNSELECTED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    input  logic [7:0]        reg_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-3:0] r_word_addr;
    logic              r_we;
    logic [3:0]        r_sel;
    logic [31:0]       r_dat;
    logic [31:0]       r_rword;
    logic [1:0]        r_idx;

    logic [2:0]  w_req_top;
    logic [2:0]  w_next_top;
    logic [3:0]  w_below_mask;
    logic [1:0]  w_first_idx;
    logic [1:0]  w_next_idx;
    logic        w_last;
    logic [31:0] w_rword_upd;
    logic        w_unused;

    assign w_unused = ^wb_adr_i[1:0];

    // Returns {any_set, index_of_highest_set_bit}.
    function automatic logic [2:0] top_lane(input logic [3:0] m);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no latch is inferred.
        w_req_top    = top_lane(wb_sel_i);
        w_below_mask = (4'b0001 << r_idx) - 4'b0001;
        w_next_top   = top_lane(r_sel & w_below_mask);
        w_first_idx  = 2'd3;
        w_next_idx   = r_idx - 2'd1;
        w_last       = (r_idx == 2'd0);
        if (SKIP_UNSELECTED != 0) begin
            w_first_idx = w_req_top[1:0];
            w_next_idx  = w_next_top[1:0];
            w_last      = !w_next_top[2];
        end
        w_rword_upd = r_rword;
        if (!r_we && r_sel[r_idx]) begin
            w_rword_upd[{r_idx, 3'b000} +: 8] = reg_rdata;
        end
    end

    // NOTE: non-blocking assignments only; ack and we default low so they pulse for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_word_addr <= '0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_dat       <= '0;
            r_rword     <= '0;
            r_idx       <= '0;
            wb_ack_o    <= 1'b0;
            wb_dat_o    <= '0;
            reg_we      <= 1'b0;
            reg_addr    <= '0;
            reg_wdata   <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            reg_we   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        r_word_addr <= wb_adr_i[ADDR_W-1:2];
                        r_we        <= wb_we_i;
                        r_sel       <= wb_sel_i;
                        r_dat       <= wb_dat_i;
                        r_rword     <= '0;
                        r_idx       <= w_first_idx;
                        if ((SKIP_UNSELECTED != 0) && (wb_sel_i == 4'b0000)) begin
                            r_state  <= S_ACK;
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= '0;
                        end else begin
                            r_state   <= S_XFER;
                            reg_addr  <= {wb_adr_i[ADDR_W-1:2], w_first_idx};
                            reg_we    <= wb_we_i & wb_sel_i[w_first_idx];
                            reg_wdata <= wb_dat_i[{w_first_idx, 3'b000} +: 8];
                        end
                    end
                end
                S_XFER: begin
                    // Dropping cyc abandons the access; committed bytes are not rolled back.
                    if (!wb_cyc_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rword <= w_rword_upd;
                        if (w_last) begin
                            r_state  <= S_ACK;
                            wb_ack_o <= 1'b1;
                            wb_dat_o <= w_rword_upd;
                        end else begin
                            r_idx     <= w_next_idx;
                            reg_addr  <= {r_word_addr, w_next_idx};
                            reg_we    <= r_we & r_sel[w_next_idx];
                            reg_wdata <= r_dat[{w_next_idx, 3'b000} +: 8];
                        end
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_wb_byte_bridge.sv
// Directed bench for sd_wb_byte_bridge: one instance per slot mode, each with a byte register-file model.
// Cycle 0 is the cycle the request is presented; outputs are sampled on the falling edge.
module tb_sd_wb_byte_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  cyc;
    logic [1:0]  stb;
    logic        we;
    logic [6:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;

    logic [31:0] dat_o  [2];
    logic        ack    [2];
    logic        rwe    [2];
    logic [6:0]  raddr  [2];
    logic [7:0]  rwdata [2];
    logic [7:0]  rdata  [2];

    sd_wb_byte_bridge #(.ADDR_W(7), .SKIP_UNSELECTED(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat_o[0]), .wb_ack_o(ack[0]),
        .reg_we(rwe[0]), .reg_addr(raddr[0]), .reg_wdata(rwdata[0]), .reg_rdata(rdata[0])
    );

    sd_wb_byte_bridge #(.ADDR_W(7), .SKIP_UNSELECTED(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_dat_i(dat), .wb_dat_o(dat_o[1]), .wb_ack_o(ack[1]),
        .reg_we(rwe[1]), .reg_addr(raddr[1]), .reg_wdata(rwdata[1]), .reg_rdata(rdata[1])
    );

    // Register-file models: combinational read, write on the clock edge; not cleared by rst.
    logic [7:0] mem0 [128] = '{default: 8'h00};
    logic [7:0] mem1 [128] = '{default: 8'h00};
    always @(posedge clk) if (rwe[0] === 1'b1) mem0[raddr[0]] <= rwdata[0];
    always @(posedge clk) if (rwe[1] === 1'b1) mem1[raddr[1]] <= rwdata[1];
    assign rdata[0] = mem0[raddr[0]];
    assign rdata[1] = mem1[raddr[1]];

    // cmd_start fires the cycle after the byte-0 write of the argument register.
    logic        cmd_start   = 1'b0;
    int          n_cmd_start = 0;
    logic [31:0] arg_snap    = '0;
    always @(posedge clk) begin
        cmd_start <= (rwe[0] === 1'b1) && (raddr[0] == 7'h00);
        if (cmd_start) begin
            n_cmd_start <= n_cmd_start + 1;
            arg_snap    <= {mem0[3], mem0[2], mem0[1], mem0[0]};
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Per-cycle trace of the register-file port during the last access, packed {we, addr, wdata}.
    logic [15:0] tr [21];

    task automatic access(input int m, input logic w, input logic [6:0] a, input logic [3:0] s,
                          input logic [31:0] d, output int lat, output logic [31:0] rd);
        bit done;
        @(negedge clk);
        cyc[m] = 1'b1; stb[m] = 1'b1; we = w; adr = a; sel = s; dat = d;
        lat  = -1;
        rd   = '0;
        done = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (!done) begin
                @(negedge clk);
                tr[k] = {rwe[m], raddr[m], rwdata[m]};
                if (ack[m] === 1'b1) begin
                    lat  = k;
                    rd   = dat_o[m];
                    done = 1'b1;
                end
            end
        end
        cyc[m] = 1'b0; stb[m] = 1'b0;
    endtask

    function automatic int count_we(input int upto);
        int n;
        n = 0;
        for (int k = 1; k <= upto; k++) n += int'(tr[k][15]);
        return n;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        int          n_ack;

        rst = 1'b1; cyc = '0; stb = '0; we = 1'b0; adr = '0; sel = '0; dat = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m0_port", {15'd0, ack[0], rwe[0], raddr[0], rwdata[0]}, 32'h0);
        check("rst_m0_dat",  dat_o[0], 32'h0);
        check("rst_m1_port", {15'd0, ack[1], rwe[1], raddr[1], rwdata[1]}, 32'h0);
        rst = 1'b0;

        // Mode 0 argument write: descending lanes, cmd_start only after lane 0.
        access(0, 1'b1, 7'h00, 4'hF, 32'h1234_5678, lat, rd);
        check("t1_lat",   lat, 5);
        check("t1_slots", {tr[1], tr[2]}, {16'h8312, 16'h8234});
        check("t1_slots_lo", {tr[3], tr[4]}, {16'h8156, 16'h8078});
        check("t1_wdat_o", rd, 32'h0);
        @(negedge clk);
        check("t1_cmd_start_cnt", n_cmd_start, 1);
        check("t1_arg_at_start",  arg_snap, 32'h1234_5678);

        // Mode 0 reads of a word holding A5C3_0F81.
        access(0, 1'b1, 7'h04, 4'hF, 32'hA5C3_0F81, lat, rd);
        access(0, 1'b0, 7'h04, 4'hF, 32'h0, lat, rd);
        check("t2_rd_lat", lat, 5);
        check("t2_rd_all", rd, 32'hA5C3_0F81);
        check("t2_rd_we",  count_we(4), 0);
        access(0, 1'b0, 7'h04, 4'b0101, 32'h0, lat, rd);
        check("t2_rd_sel5_lat", lat, 5);
        check("t2_rd_sel5", rd, 32'h00C3_0081);
        repeat (3) @(negedge clk);
        check("t2_dat_hold", dat_o[0], 32'h00C3_0081);

        // Mode 0 single-lane write: only the lane-1 slot (cycle 3) writes.
        access(0, 1'b1, 7'h08, 4'b0010, 32'hFFFF_AAFF, lat, rd);
        check("t3_lat", lat, 5);
        check("t3_slots_hi", {tr[1], tr[2]}, {16'h0BFF, 16'h0AFF});
        check("t3_slots_lo", {tr[3], tr[4]}, {16'h89AA, 16'h08FF});
        check("t3_mem", {mem0[11], mem0[10], mem0[9], mem0[8]}, 32'h0000_AA00);

        // Mode 1: only selected lanes get slots.
        access(1, 1'b1, 7'h10, 4'b1001, 32'h1122_3344, lat, rd);
        check("t4_lat", lat, 3);
        check("t4_slots", {tr[1], tr[2]}, {16'h9311, 16'h9044});
        access(1, 1'b1, 7'h14, 4'b0000, 32'hFFFF_FFFF, lat, rd);
        check("t4_sel0_lat", lat, 1);
        check("t4_sel0_we",  count_we(1), 0);
        check("t4_sel0_mem", {mem1[23], mem1[22], mem1[21], mem1[20]}, 32'h0);
        access(1, 1'b0, 7'h10, 4'b1001, 32'h0, lat, rd);
        check("t4_rd_lat", lat, 3);
        check("t4_rd", rd, 32'h1100_0044);
        access(1, 1'b0, 7'h10, 4'hF, 32'h0, lat, rd);
        check("t4_rd_all_lat", lat, 5);
        check("t4_rd_all", rd, 32'h1100_0044);

        // Abort: cyc drops during the lane-2 slot, so lanes 3 and 2 commit and nothing else.
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we = 1'b1; adr = 7'h20; sel = 4'hF; dat = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        cyc[0] = 1'b0; stb[0] = 1'b0;
        n_ack = 0;
        for (int k = 3; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) check("t5_we_after_abort", rwe[0], 1'b0);
            n_ack += int'(ack[0]);
        end
        check("t5_no_ack", n_ack, 0);
        check("t5_mem", {mem0[35], mem0[34], mem0[33], mem0[32]}, 32'hDEAD_0000);
        access(0, 1'b0, 7'h20, 4'hF, 32'h0, lat, rd);
        check("t5_next_lat", lat, 5);
        check("t5_next_rd", rd, 32'hDEAD_0000);

        // Reset during the lane-3 slot: lane 3 commits, outputs clear on that edge.
        access(0, 1'b1, 7'h30, 4'hF, 32'h0102_0304, lat, rd);
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we = 1'b1; adr = 7'h30; sel = 4'hF; dat = 32'hAABB_CCDD;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cyc[0] = 1'b0; stb[0] = 1'b0;
        check("t6_port_after_rst", {15'd0, ack[0], rwe[0], raddr[0], rwdata[0]}, 32'h0);
        check("t6_dat_after_rst", dat_o[0], 32'h0);
        access(0, 1'b0, 7'h30, 4'hF, 32'h0, lat, rd);
        check("t6_rd_lat", lat, 5);
        check("t6_rd", rd, 32'hAA02_0304);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
